// File: rtl/i2c_read_sched.sv
// rtl/i2c_read_sched.sv - round-robin scheduler sharing one I2C register-read engine
//
// Purpose: grants one of NUM_REQ requesters at a time, and drives the shared read
// engine with that requester's {device, register} address. It then returns the read
// byte, or a timeout error, to the granted requester.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req               per-requester level request, held until its o_rsp_valid bit
//   i_dev_addr          requester i device address at [7i+6:7i]
//   i_reg_addr          requester i register address at [8i+7:8i]
//   o_gnt               one-hot grant, high from LAUNCH through RESP
//   o_rsp_valid         one-cycle response pulse to the granted requester
//   o_rsp_data          read byte (0 on timeout), held until the next response
//   o_rsp_err           timeout flag, held until the next response
//   o_busy              high whenever the scheduler is not idle
//   o_eng_ena           engine enable; the engine runs while high, resets while low
//   o_eng_dev_addr      latched device address for the engine
//   o_eng_reg_addr      latched register address for the engine
//   i_eng_data          engine read data
//   i_eng_done          engine completion flag (level)
module i2c_read_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int GAP_CYC     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [7*NUM_REQ-1:0]   i_dev_addr,
  input  logic [8*NUM_REQ-1:0]   i_reg_addr,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [7:0]             o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_eng_ena,
  output logic [6:0]             o_eng_dev_addr,
  output logic [7:0]             o_eng_reg_addr,
  input  logic [7:0]             i_eng_data,
  input  logic                   i_eng_done
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done_q;

  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_REQ-1:0] w_onehot;
  logic [6:0]         w_dev;
  logic [7:0]         w_reg;
  logic               w_cmpl;

  // First set request at or after r_rr_ptr, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] w_j;
    int               j;
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      w_j = IDX_W'(j);
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_sel   = w_j;
      end
    end
  end

  assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

  // Address slice of the granted requester.
  always_comb begin
    w_dev = '0;
    w_reg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dev = i_dev_addr[7*i +: 7];
        w_reg = i_reg_addr[8*i +: 8];
      end
    end
  end

  // Only a fresh rising edge counts, so a done flag left high by the previous
  // transaction cannot complete the next one.
  assign w_cmpl = i_eng_done & ~r_done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_done_q       <= 1'b0;
      o_gnt          <= '0;
      o_rsp_valid    <= '0;
      o_rsp_data     <= '0;
      o_rsp_err      <= 1'b0;
      o_busy         <= 1'b0;
      o_eng_ena      <= 1'b0;
      o_eng_dev_addr <= '0;
      o_eng_reg_addr <= '0;
    end else begin
      r_done_q <= i_eng_done;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            o_gnt   <= w_onehot;
            r_idx   <= w_sel;
            o_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          o_eng_dev_addr <= w_dev;
          o_eng_reg_addr <= w_reg;
          o_eng_ena      <= 1'b1;
          r_cnt          <= '0;
          r_state        <= S_BUSY;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Completion is tested first so it wins a tie with the timeout.
          if (w_cmpl) begin
            o_rsp_data  <= i_eng_data;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= o_gnt;
            r_state     <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= o_gnt;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          o_rsp_valid <= '0;
          o_eng_ena   <= 1'b0;
          o_gnt       <= '0;
          r_rr_ptr    <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
          r_cnt       <= '0;
          r_state     <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_read_sched.sv
// tb/tb_i2c_read_sched.sv - self-checking bench for i2c_read_sched
module tb_i2c_read_sched;

  localparam int N   = 4;
  localparam int TO  = 100;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [7*N-1:0] dev_addr;
  logic [8*N-1:0] reg_addr;
  logic [N-1:0] gnt;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         eng_ena;
  logic [6:0]   eng_dev_addr;
  logic [7:0]   eng_reg_addr;
  logic [7:0]   eng_data = 8'h00;
  logic         eng_done = 1'b0;

  int checks = 0;
  int errors = 0;

  // Engine model knobs
  int lat_cfg   = 1000000;
  int drop_at   = 0;
  bit hold_done = 1'b0;
  int ecnt      = 0;
  logic [7:0] mem [256];

  // Reference model state
  int ptr = 0;
  int last_lows = 0;
  int tail = 0;

  always #5 clk = ~clk;

  i2c_read_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_dev_addr(dev_addr), .i_reg_addr(reg_addr),
    .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_busy(busy), .o_eng_ena(eng_ena), .o_eng_dev_addr(eng_dev_addr),
    .o_eng_reg_addr(eng_reg_addr), .i_eng_data(eng_data), .i_eng_done(eng_done)
  );

  // Engine: counts enabled cycles, raises done after lat_cfg of them with the byte
  // stored at its latched address. Before drop_at the previous done level is kept.
  always @(negedge clk) begin
    if (eng_ena !== 1'b1) begin
      ecnt = 0;
      if (!hold_done) eng_done = 1'b0;
    end else begin
      ecnt = ecnt + 1;
      if (ecnt >= lat_cfg) begin
        if (!eng_done) eng_data = mem[eng_reg_addr ^ {1'b0, eng_dev_addr}];
        eng_done = 1'b1;
      end else if (ecnt > drop_at) begin
        eng_done = 1'b0;
        eng_data = 8'($urandom);
      end
    end
  end

  function automatic logic [7:0] exp_data(input logic [6:0] d, input logic [7:0] r);
    return mem[r ^ {1'b0, d}];
  endfunction

  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [6:0] get_dev(input int i);
    return dev_addr[7*i +: 7];
  endfunction

  function automatic logic [7:0] get_reg(input int i);
    return reg_addr[8*i +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [6:0] d, input logic [7:0] r);
    dev_addr[7*i +: 7] = d;
    reg_addr[8*i +: 8] = r;
  endtask

  task automatic wait_launch(output int lows, output int to);
    lows = 0;
    to = 0;
    while (1) begin
      step();
      if (eng_ena === 1'b1) break;
      lows++;
      if (lows > 2000) begin to = 1; break; end
    end
  endtask

  task automatic wait_resp(output int highs, output logic [3:0] v, output logic [7:0] d,
                           output logic e, output logic [3:0] vn, output int to);
    int n;
    highs = 0;
    to = 0;
    n = 0;
    while (rsp_valid === 4'b0000) begin
      if (eng_ena === 1'b1) highs++;
      n++;
      if (n > 3000) begin to = 1; break; end
      step();
    end
    v = rsp_valid;
    d = rsp_data;
    e = rsp_err;
    step();
    vn = rsp_valid;
    tail = (eng_ena === 1'b0) ? 1 : 0;
  endtask

  task automatic run_txn(input string tag, output int lows, output int highs, output logic [3:0] gl,
                         output logic [6:0] da, output logic [7:0] ra, output logic [3:0] v,
                         output logic [7:0] d, output logic e, output logic [3:0] vn);
    int to1, to2;
    wait_launch(lows, to1);
    gl = gnt;
    da = eng_dev_addr;
    ra = eng_reg_addr;
    wait_resp(highs, v, d, e, vn, to2);
    chk({tag, "_bound"}, 32'(to1 + to2), 0);
  endtask

  // Successful transaction for requester idx: checks routing, data and latency.
  task automatic txn_std(input string tag, input int idx, input int lat, input int dropat);
    int lows, highs;
    logic [3:0] gl, v, vn;
    logic [6:0] da, edev;
    logic [7:0] ra, d, ereg;
    logic e;
    lat_cfg = lat;
    drop_at = dropat;
    edev = get_dev(idx);
    ereg = get_reg(idx);
    run_txn(tag, lows, highs, gl, da, ra, v, d, e, vn);
    chk({tag, "_gnt"}, 32'(gl), 32'(1 << idx));
    chk({tag, "_dev"}, 32'(da), 32'(edev));
    chk({tag, "_reg"}, 32'(ra), 32'(ereg));
    chk({tag, "_valid"}, 32'(v), 32'(1 << idx));
    chk({tag, "_data"}, 32'(d), 32'(exp_data(edev, ereg)));
    chk({tag, "_err"}, 32'(e), 0);
    chk({tag, "_busy_cyc"}, 32'(highs), 32'(lat));
    chk({tag, "_pulse"}, 32'(vn), 0);
    last_lows = lows;
    ptr = (idx + 1) % N;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("idle_bound", 32'(busy), 0);
  endtask

  initial begin
    int idx, r, lows, highs, to, bc, prev_tail;
    logic [3:0] gl, v, vn;
    logic [6:0] da, d2;
    logic [7:0] ra, d, r2;
    logic e;

    rst = 1'b1;
    req = '0;
    dev_addr = '0;
    reg_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h0F ^ 8'h48] = 8'hA5;

    // Reset state
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ena", 32'(eng_ena), 0);
    chk("rst_dev", 32'(eng_dev_addr), 0);
    chk("rst_reg", 32'(eng_reg_addr), 0);
    rst = 1'b0;
    step();

    // All requesters continuously requesting: order 0,1,2,3,0
    for (int i = 0; i < N; i++) set_addr(i, 7'(7'h20 + i), 8'($urandom));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      idx = arb(req, ptr);
      chk("rr_order", 32'(idx), 32'(t % N));
      prev_tail = tail;
      txn_std("rr", idx, $urandom_range(3, 60), 0);
      if (t == 0) chk("rr_ena_lat", 32'(last_lows + 1), 2);
      else chk("rr_ena_gap", 32'(prev_tail + last_lows), 32'(GAP + 2));
      set_addr(idx, 7'($urandom), 8'($urandom));
    end
    req = '0;

    // Single request, 48/0F, data A5 after 50 cycles
    wait_idle();
    set_addr(0, 7'h48, 8'h0F);
    req = 4'b0001;
    idx = arb(req, ptr);
    txn_std("single", idx, 50, 0);
    chk("single_ena_lat", 32'(last_lows + 1), 2);
    req = '0;
    bc = 0;
    while (busy === 1'b1 && bc < 50) begin bc++; step(); end
    chk("single_busy_tail", 32'(bc), 32'(GAP));

    // Timeout: engine never completes
    wait_idle();
    r = $urandom_range(0, N - 1);
    set_addr(r, 7'($urandom), 8'($urandom));
    lat_cfg = 1000000;
    drop_at = 0;
    req = 4'(1 << r);
    run_txn("tmo", lows, highs, gl, da, ra, v, d, e, vn);
    chk("tmo_valid", 32'(v), 32'(1 << r));
    chk("tmo_data", 32'(d), 0);
    chk("tmo_err", 32'(e), 1);
    chk("tmo_busy_cyc", 32'(highs), 32'(TO));
    req = '0;
    ptr = (r + 1) % N;

    // Stale done held across GAP, then a completion/timeout tie
    wait_idle();
    hold_done = 1'b1;
    r = $urandom_range(0, N - 1);
    set_addr(r, 7'($urandom), 8'($urandom));
    req = 4'(1 << r);
    txn_std("stale_a", r, 30, 0);
    req = '0;
    r = (r + 1) % N;
    set_addr(r, 7'($urandom), 8'($urandom));
    wait_idle();
    chk("stale_held", 32'(eng_done), 1);
    req = 4'(1 << r);
    txn_std("stale_b", r, 40, 20);
    req = '0;
    r = (r + 1) % N;
    set_addr(r, 7'($urandom), 8'($urandom));
    req = 4'(1 << r);
    txn_std("tie", r, TO, 0);
    req = '0;
    hold_done = 1'b0;

    // Requester 2 changes reg_addr and drops req while busy
    wait_idle();
    d2 = 7'($urandom);
    r2 = 8'($urandom);
    set_addr(2, d2, r2);
    lat_cfg = 30;
    drop_at = 0;
    req = 4'b0100;
    wait_launch(lows, to);
    chk("chg_launch_bound", 32'(to), 0);
    set_addr(2, d2, r2 ^ 8'hFF);
    req = '0;
    repeat (5) step();
    chk("chg_reg_stable", 32'(eng_reg_addr), 32'(r2));
    chk("chg_dev_stable", 32'(eng_dev_addr), 32'(d2));
    wait_resp(highs, v, d, e, vn, to);
    chk("chg_resp_bound", 32'(to), 0);
    chk("chg_valid", 32'(v), 32'(4'b0100));
    chk("chg_data", 32'(d), 32'(exp_data(d2, r2)));
    ptr = 3;

    // Reset in the middle of BUSY, pending requests re-arbitrated from index 0
    wait_idle();
    lat_cfg = 1000000;
    req = 4'b1010;
    idx = arb(req, ptr);
    wait_launch(lows, to);
    chk("mid_launch_bound", 32'(to), 0);
    chk("mid_gnt", 32'(gnt), 32'(1 << idx));
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ena", 32'(eng_ena), 0);
    chk("mid_rst_dev", 32'(eng_dev_addr), 0);
    chk("mid_rst_reg", 32'(eng_reg_addr), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    chk("mid_rst_err", 32'(rsp_err), 0);
    rst = 1'b0;
    ptr = 0;
    step();
    idx = arb(req, ptr);
    chk("mid_regrant", 32'(gnt), 32'(1 << idx));
    txn_std("mid_after", idx, 25, 0);
    req = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
